// File: rtl/trace_lane_serializer.sv
// trace_lane_serializer
//   Serializes the two-lane retired-instruction trace bundle into a single-lane
//   ready/valid stream. Records are buffered in program order (lane 0 before
//   lane 1). Records that do not fit are dropped. Drops are counted, flagged,
//   and marked on the next record that is stored.
// Ports:
//   clock, reset (async, active low)
//   in_{0,1}_*   : per-lane trace record (valid/iaddr/insn/priv/exception/
//                  interrupt/cause/tval)
//   out_valid/out_ready/out_* : head-of-FIFO record; out_lost marks a gap
//                  before this record
//   overflow     : sticky drop flag
//   drop_count   : saturating count of dropped records
//   clear        : synchronous clear of overflow/drop_count
module trace_lane_serializer #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_0_valid,
  input  logic [39:0]       in_0_iaddr,
  input  logic [31:0]       in_0_insn,
  input  logic [2:0]        in_0_priv,
  input  logic              in_0_exception,
  input  logic              in_0_interrupt,
  input  logic [63:0]       in_0_cause,
  input  logic [39:0]       in_0_tval,
  input  logic              in_1_valid,
  input  logic [39:0]       in_1_iaddr,
  input  logic [31:0]       in_1_insn,
  input  logic [2:0]        in_1_priv,
  input  logic              in_1_exception,
  input  logic              in_1_interrupt,
  input  logic [63:0]       in_1_cause,
  input  logic [39:0]       in_1_tval,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [39:0]       out_iaddr,
  output logic [31:0]       out_insn,
  output logic [2:0]        out_priv,
  output logic              out_exception,
  output logic              out_interrupt,
  output logic [63:0]       out_cause,
  output logic [39:0]       out_tval,
  output logic              out_lost,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  input  logic              clear
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        lost;
    logic [39:0] iaddr;
    logic [31:0] insn;
    logic [2:0]  priv;
    logic        exception;
    logic        interrupt;
    logic [63:0] cause;
    logic [39:0] tval;
  } rec_t;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, free;
  logic          pending_lost;

  rec_t          lane0, lane1, wr0, wr1, head;
  logic [1:0]    acc, drop, enq_num, ndrop;
  logic          deq;
  logic [DROP_W:0] drop_sum;

  always_comb begin
    lane0 = '{1'b0, in_0_iaddr, in_0_insn, in_0_priv, in_0_exception,
              in_0_interrupt, in_0_cause, in_0_tval};
    lane1 = '{1'b0, in_1_iaddr, in_1_insn, in_1_priv, in_1_exception,
              in_1_interrupt, in_1_cause, in_1_tval};
    // Space is what was free at the start of the cycle; a same-cycle dequeue
    // does not make room.
    free    = CW'(DEPTH) - count;
    acc[0]  = in_0_valid && (free != '0);
    acc[1]  = in_1_valid && (free >= (acc[0] ? CW'(2) : CW'(1)));
    drop[0] = in_0_valid && !acc[0];
    drop[1] = in_1_valid && !acc[1];
    enq_num = {1'b0, acc[0]} + {1'b0, acc[1]};
    ndrop   = {1'b0, drop[0]} + {1'b0, drop[1]};
    // The first stored record carries the gap marker from earlier drops.
    wr0      = acc[0] ? lane0 : lane1;
    wr0.lost = pending_lost;
    wr1      = lane1;
    deq      = out_valid && out_ready;
    drop_sum = {1'b0, drop_count} + (DROP_W+1)'(ndrop);
  end

  // Payload storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clock) begin
    if (enq_num != 2'd0) mem[wptr]          <= wr0;
    if (enq_num == 2'd2) mem[wptr + AW'(1)] <= wr1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      pending_lost <= 1'b0;
      overflow     <= 1'b0;
      drop_count   <= '0;
    end else begin
      wptr  <= wptr + AW'(enq_num);
      rptr  <= rptr + AW'(deq);
      count <= count + CW'(enq_num) - CW'(deq);
      if (ndrop != 2'd0)         pending_lost <= 1'b1;
      else if (enq_num != 2'd0)  pending_lost <= 1'b0;
      // A drop in the same cycle as clear wins over the clear.
      if (clear) begin
        overflow   <= (ndrop != 2'd0);
        drop_count <= DROP_W'(ndrop);
      end else begin
        overflow   <= overflow | (ndrop != 2'd0);
        drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
    end
  end

  assign out_valid     = (count != '0);
  assign head          = out_valid ? mem[rptr] : '0;
  assign out_iaddr     = head.iaddr;
  assign out_insn      = head.insn;
  assign out_priv      = head.priv;
  assign out_exception = head.exception;
  assign out_interrupt = head.interrupt;
  assign out_cause     = head.cause;
  assign out_tval      = head.tval;
  assign out_lost      = head.lost;
endmodule

// File: tb/tb_trace_lane_serializer.sv
// Directed bench for trace_lane_serializer (DEPTH=8, DROP_W=16).
module tb_trace_lane_serializer;
  logic        clock = 0, reset = 0;
  logic        in_0_valid = 0, in_0_exception = 0, in_0_interrupt = 0;
  logic [39:0] in_0_iaddr = 0, in_0_tval = 0;
  logic [31:0] in_0_insn = 0;
  logic [2:0]  in_0_priv = 0;
  logic [63:0] in_0_cause = 0;
  logic        in_1_valid = 0, in_1_exception = 0, in_1_interrupt = 0;
  logic [39:0] in_1_iaddr = 0, in_1_tval = 0;
  logic [31:0] in_1_insn = 0;
  logic [2:0]  in_1_priv = 0;
  logic [63:0] in_1_cause = 0;
  logic        out_valid, out_ready = 0;
  logic [39:0] out_iaddr, out_tval;
  logic [31:0] out_insn;
  logic [2:0]  out_priv;
  logic        out_exception, out_interrupt, out_lost, overflow;
  logic [63:0] out_cause;
  logic [15:0] drop_count;
  logic        clear = 0;

  int checks = 0, failures = 0;

  trace_lane_serializer #(.DEPTH(8), .DROP_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_0_valid(in_0_valid), .in_0_iaddr(in_0_iaddr), .in_0_insn(in_0_insn),
    .in_0_priv(in_0_priv), .in_0_exception(in_0_exception),
    .in_0_interrupt(in_0_interrupt), .in_0_cause(in_0_cause), .in_0_tval(in_0_tval),
    .in_1_valid(in_1_valid), .in_1_iaddr(in_1_iaddr), .in_1_insn(in_1_insn),
    .in_1_priv(in_1_priv), .in_1_exception(in_1_exception),
    .in_1_interrupt(in_1_interrupt), .in_1_cause(in_1_cause), .in_1_tval(in_1_tval),
    .out_valid(out_valid), .out_ready(out_ready), .out_iaddr(out_iaddr),
    .out_insn(out_insn), .out_priv(out_priv), .out_exception(out_exception),
    .out_interrupt(out_interrupt), .out_cause(out_cause), .out_tval(out_tval),
    .out_lost(out_lost), .overflow(overflow), .drop_count(drop_count), .clear(clear)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic lanes(input logic v0, input logic [39:0] a0,
                       input logic v1, input logic [39:0] a1);
    in_0_valid = v0; in_0_iaddr = a0;
    in_1_valid = v1; in_1_iaddr = a1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (drop_count !== 16'h0) begin failures++; $display("FAIL reset_drop got=%h exp=0", drop_count); end
    checks++; if (out_iaddr !== 40'h0 || out_cause !== 64'h0) begin failures++; $display("FAIL reset_data iaddr=%h cause=%h exp=0", out_iaddr, out_cause); end
    #2 reset = 1;
    @(negedge clock);
  endtask

  task automatic test_single();
    out_ready = 1;
    lanes(1, 40'h80000000, 0, 0);
    in_0_insn = 32'h00000013; in_0_priv = 3'd3; in_0_cause = 64'h8000_0000_0000_000b;
    in_0_tval = 40'h12_3456_789a; in_0_interrupt = 1;
    tick();
    lanes(0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_iaddr !== 40'h80000000 || out_insn !== 32'h13)
      begin failures++; $display("FAIL single_rec v=%b iaddr=%h insn=%h exp 1/80000000/13", out_valid, out_iaddr, out_insn); end
    checks++; if (out_priv !== 3'd3 || out_cause !== 64'h8000_0000_0000_000b || out_tval !== 40'h12_3456_789a || out_interrupt !== 1'b1 || out_exception !== 1'b0)
      begin failures++; $display("FAIL single_fields priv=%0d cause=%h tval=%h int=%b exc=%b", out_priv, out_cause, out_tval, out_interrupt, out_exception); end
    checks++; if (out_lost !== 1'b0) begin failures++; $display("FAIL single_lost got=%b exp=0", out_lost); end
    in_0_priv = 0; in_0_cause = 0; in_0_tval = 0; in_0_interrupt = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_dual();
    logic [39:0] exp_a [3];
    exp_a[0] = 40'h1000; exp_a[1] = 40'h1004; exp_a[2] = 40'h1008;
    out_ready = 1;
    lanes(1, 40'h1000, 1, 40'h1004);
    in_1_exception = 1; in_1_cause = 64'd2;
    tick();
    in_1_exception = 0; in_1_cause = 0;
    lanes(0, 0, 1, 40'h1008);
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_iaddr !== exp_a[k])
        begin failures++; $display("FAIL dual_order[%0d] v=%b iaddr=%h exp=%h", k, out_valid, out_iaddr, exp_a[k]); end
      if (k == 1) begin
        checks++; if (out_exception !== 1'b1 || out_cause !== 64'd2)
          begin failures++; $display("FAIL dual_lane1_fields exc=%b cause=%h exp 1/2", out_exception, out_cause); end
      end
      tick();
      lanes(0, 0, 0, 0);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dual_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      lanes(1, 40'h2000 + 40'(8*c), 1, 40'h2004 + 40'(8*c));
      tick();
    end
    lanes(0, 0, 0, 0);
    checks++; if (drop_count !== 16'd2 || overflow !== 1'b1)
      begin failures++; $display("FAIL ovf_drop cnt=%0d ovf=%b exp 2/1", drop_count, overflow); end
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1 || out_iaddr !== 40'h2000 + 40'(4*k) || out_lost !== 1'b0)
        begin failures++; $display("FAIL ovf_drain[%0d] v=%b iaddr=%h lost=%b exp iaddr=%h lost=0", k, out_valid, out_iaddr, out_lost, 40'h2000 + 40'(4*k)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
    lanes(1, 40'h3000, 0, 0);
    tick();
    lanes(0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_iaddr !== 40'h3000 || out_lost !== 1'b1)
      begin failures++; $display("FAIL ovf_lost v=%b iaddr=%h lost=%b exp 1/3000/1", out_valid, out_iaddr, out_lost); end
    tick();
  endtask

  task automatic test_partial();
    logic [39:0] exp_a [7];
    out_ready = 0; clear = 1;
    tick();
    clear = 0;
    checks++; if (drop_count !== 16'd0 || overflow !== 1'b0)
      begin failures++; $display("FAIL clear_idle cnt=%0d ovf=%b exp 0/0", drop_count, overflow); end
    for (int c = 0; c < 3; c++) begin
      lanes(1, 40'h4000 + 40'(8*c), 1, 40'h4004 + 40'(8*c));
      tick();
    end
    lanes(1, 40'h4018, 0, 0);
    tick();
    out_ready = 1;
    lanes(1, 40'h5000, 1, 40'h5004);
    tick();
    lanes(0, 0, 0, 0);
    checks++; if (drop_count !== 16'd1 || overflow !== 1'b1)
      begin failures++; $display("FAIL partial_drop cnt=%0d ovf=%b exp 1/1", drop_count, overflow); end
    for (int k = 0; k < 6; k++) exp_a[k] = 40'h4004 + 40'(4*k);
    exp_a[6] = 40'h5000;
    for (int k = 0; k < 7; k++) begin
      checks++; if (out_valid !== 1'b1 || out_iaddr !== exp_a[k] || out_lost !== 1'b0)
        begin failures++; $display("FAIL partial_drain[%0d] v=%b iaddr=%h lost=%b exp iaddr=%h lost=0", k, out_valid, out_iaddr, out_lost, exp_a[k]); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL partial_empty got=%b exp=0", out_valid); end
    lanes(1, 40'h6000, 0, 0);
    tick();
    lanes(0, 0, 0, 0);
    checks++; if (out_iaddr !== 40'h6000 || out_lost !== 1'b1)
      begin failures++; $display("FAIL partial_lost iaddr=%h lost=%b exp 6000/1", out_iaddr, out_lost); end
    tick();
  endtask

  task automatic test_saturate();
    out_ready = 0;
    lanes(1, 40'hA000, 1, 40'hA004);
    // 4 cycles fill, 32768 dual-drop cycles reach 65536 drops
    for (int c = 0; c < 32800; c++) tick();
    checks++; if (drop_count !== 16'hFFFF || overflow !== 1'b1)
      begin failures++; $display("FAIL sat_reach cnt=%h ovf=%b exp ffff/1", drop_count, overflow); end
    for (int c = 0; c < 10; c++) tick();
    checks++; if (drop_count !== 16'hFFFF)
      begin failures++; $display("FAIL sat_hold cnt=%h exp ffff", drop_count); end
    lanes(0, 0, 0, 0); clear = 1;
    tick();
    checks++; if (drop_count !== 16'd0 || overflow !== 1'b0)
      begin failures++; $display("FAIL sat_clear cnt=%h ovf=%b exp 0/0", drop_count, overflow); end
    lanes(1, 40'hB000, 1, 40'hB004);
    tick();
    lanes(0, 0, 0, 0); clear = 0;
    checks++; if (drop_count !== 16'd2 || overflow !== 1'b1)
      begin failures++; $display("FAIL clear_vs_drop cnt=%0d ovf=%b exp 2/1", drop_count, overflow); end
    out_ready = 1;
    for (int c = 0; c < 8; c++) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_drain v=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    lanes(1, 40'hC000, 1, 40'hC004);
    tick();
    lanes(1, 40'hC008, 1, 40'hC00C);
    tick();
    lanes(0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_iaddr !== 40'hC000)
      begin failures++; $display("FAIL arst_pre v=%b iaddr=%h exp 1/c000", out_valid, out_iaddr); end
    #2 reset = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_iaddr !== 40'h0 || drop_count !== 16'd0 || overflow !== 1'b0)
      begin failures++; $display("FAIL arst_now v=%b iaddr=%h cnt=%0d ovf=%b exp all 0", out_valid, out_iaddr, drop_count, overflow); end
    @(negedge clock);
    reset = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_after v=%b exp=0", out_valid); end
    out_ready = 1;
    lanes(1, 40'hD000, 0, 0);
    tick();
    lanes(0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_iaddr !== 40'hD000 || out_lost !== 1'b0)
      begin failures++; $display("FAIL arst_first v=%b iaddr=%h lost=%b exp 1/d000/0", out_valid, out_iaddr, out_lost); end
    tick();
  endtask

  initial begin
    #3;
    test_reset();
    test_single();
    test_dual();
    test_overflow();
    test_partial();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
